output_subsystem: RTL and testbench
===================================

OUTPUT_SUBSYSTEM -- requirements
Module: output_subsystem

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART line rate.
REQ-003 SHALL have ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- w_en_output  in  1  FSM enable; low forces IDLE.
- w_start  in  1  one-cycle pulse that begins printing one matrix.
- w_base_addr  in  8  storage address of element (0,0).
- w_dim_m  in  3  row count.
- w_dim_n  in  3  column count.
- w_rd_en  out  1  storage read strobe.
- w_rd_addr  out  8  storage read address.
- w_rd_data  in  32  storage read data, unsigned.
- uart_tx  out  1  serial line, idle high.
- w_busy  out  1  high from an accepted start until done.
- w_tx_done  out  1  one-cycle pulse after the last byte leaves the line.
- w_error_flag  out  1  dimension error, sticky until next start or enable low.

Function
REQ-004 SHALL accept w_start only in IDLE with w_en_output high; w_start at any other time SHALL be ignored.
REQ-005 SHALL set w_error_flag, send nothing, and stay in IDLE when w_dim_m or w_dim_n is outside 1..5 at start.
REQ-006 SHALL read elements row-major, with address = w_base_addr + r*n + c (8-bit wrap), and SHALL use read data exactly one cycle after w_rd_en.
REQ-007 SHALL assert w_rd_en for one cycle per element and SHALL hold w_rd_addr stable that cycle.
REQ-008 SHALL convert each element to decimal ASCII ('0'=48) with leading zeros suppressed, so that 0 prints as "0", and SHALL allow up to 10 digits.
REQ-009 SHALL convert by sequential subtraction of powers of ten (10^9 down to 10^0), one compare/subtract per cycle, and SHALL use no divider.
REQ-010 SHALL send a space (32) after every element except the last in a row, and SHALL send CR (13) then LF (10) after each row.
REQ-011 SHALL use states IDLE, READ, WAIT_RD, CONV, SEND_DIGIT, SEND_SEP, SEND_CRLF and DONE.
REQ-012 SHALL follow these transitions: IDLE->READ on a valid start; READ->WAIT_RD; WAIT_RD->CONV; CONV->SEND_DIGIT when the digit buffer is complete; SEND_DIGIT->SEND_SEP or SEND_CRLF; SEND_SEP->READ; SEND_CRLF->READ, or ->DONE after the last row; DONE->IDLE after one cycle.
REQ-013 SHALL present each byte to the transmitter only when it is idle, with exactly one byte per transmitter start and no byte dropped or duplicated.
REQ-014 SHALL pulse w_tx_done in DONE, which is entered only after the final LF stop bit completes.
REQ-015 SHALL abort any transfer when w_en_output goes low: return to IDLE the next cycle, clear w_busy and w_error_flag, let the byte in flight finish on the line, and emit no w_tx_done.
REQ-016 SHALL clear w_error_flag on an accepted start.

Reset
REQ-017 SHALL, on rst high at a clock edge, enter IDLE and drive uart_tx=1, w_rd_en=0, w_rd_addr=0, w_busy=0, w_tx_done=0 and w_error_flag=0.
REQ-018 SHALL, on reset mid-frame, force uart_tx high immediately (the truncated byte is acceptable) and discard all counters.

Configuration
REQ-019 SHALL, with OUTPUT_SIGNED_EN defined, treat w_rd_data as two's complement and prefix '-' (45) to negative values before the magnitude digits.
REQ-020 SHALL, with OUTPUT_SIGNED_EN undefined, treat all data as unsigned and never emit '-'.

Structure
REQ-021 SHALL take ASCII constants (ASC_0, ASC_SPACE, ASC_CR, ASC_LF, ASC_MINUS) and the state encoding from a shared package.
REQ-022 SHALL instantiate one sub-module, uart_tx (CLK_FREQ, BAUD_RATE; ports tx_data[7:0], tx_start, tx_busy, tx), as the counterpart of the existing uart_rx.

Verification
REQ-023 Bench SHALL cover: 2x3 matrix of 1,2,3,4,5,6 -> bytes "1 2 3\r\n4 5 6\r\n", then one w_tx_done pulse.
REQ-024 Bench SHALL cover: 1x1 element 0 -> "0\r\n"; element 4294967295 unsigned -> "4294967295\r\n".
REQ-025 Bench SHALL cover: w_dim_m=0 or w_dim_n=6 at start -> w_error_flag=1, uart_tx stays high, w_busy stays 0.
REQ-026 Bench SHALL cover: with OUTPUT_SIGNED_EN defined, element 32'hFFFFFFF6 -> "-10\r\n"; without the macro -> "4294967286\r\n".
REQ-027 Bench SHALL cover: w_en_output dropped during row 2 of a 5x5 matrix -> IDLE the next cycle, no w_tx_done, and a fresh start then prints the full matrix correctly.
REQ-028 Bench SHALL cover: w_base_addr=250 with a 3x3 matrix -> read addresses 250..255, then 0..2.

Source files
------------

// File: rtl/output_subsystem_pkg.sv
// Shared definitions for the matrix output subsystem: FSM encoding, ASCII
// constants and the power-of-ten table used by the decimal converter.
package output_subsystem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_RD,
    CONV,
    SEND_DIGIT,
    SEND_SEP,
    SEND_CRLF,
    DONE
  } state_t;

  localparam logic [7:0] ASC_0     = 8'd48;
  localparam logic [7:0] ASC_SPACE = 8'd32;
  localparam logic [7:0] ASC_CR    = 8'd13;
  localparam logic [7:0] ASC_LF    = 8'd10;
  localparam logic [7:0] ASC_MINUS = 8'd45;

  localparam logic [2:0] DIM_MAX  = 3'd5;
  localparam int         BUF_LEN  = 11;  // optional sign plus ten digits

  function automatic logic [31:0] pow10(input logic [3:0] idx);
    logic [31:0] p;
    case (idx)
      4'd0:    p = 32'd1;
      4'd1:    p = 32'd10;
      4'd2:    p = 32'd100;
      4'd3:    p = 32'd1_000;
      4'd4:    p = 32'd10_000;
      4'd5:    p = 32'd100_000;
      4'd6:    p = 32'd1_000_000;
      4'd7:    p = 32'd10_000_000;
      4'd8:    p = 32'd100_000_000;
      default: p = 32'd1_000_000_000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/output_subsystem_uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, one stop bit.
// tx_busy stays high until the stop bit has completed on the line.
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch reads the values from the start of the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
        shreg    <= {1'b1, tx_data};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        // The stop bit rides in shreg[8] and is shifted out as bit 9.
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/output_subsystem.sv
// Prints an m x n matrix from storage as decimal ASCII over a UART, rows
// ended by CR LF. Define OUTPUT_SIGNED_EN to print elements as signed.
module output_subsystem
  import output_subsystem_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en_output,
  input  logic        w_start,
  input  logic [7:0]  w_base_addr,
  input  logic [2:0]  w_dim_m,
  input  logic [2:0]  w_dim_n,
  output logic        w_rd_en,
  output logic [7:0]  w_rd_addr,
  input  logic [31:0] w_rd_data,
  output logic        uart_tx,
  output logic        w_busy,
  output logic        w_tx_done,
  output logic        w_error_flag
);

  state_t      state;
  logic [2:0]  dim_m, dim_n, row, col;
  logic [31:0] conv_val;
  logic [3:0]  pow_idx;
  logic [3:0]  digit;
  logic        started;
  logic [7:0]  dbuf [BUF_LEN];
  logic [3:0]  dlen, didx;
  logic [1:0]  crlf_phase;

  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        can_send;
  logic        dims_bad;

  // A start pulse is still in flight for one cycle before tx_busy rises.
  assign can_send = !tx_busy && !tx_start;
  assign dims_bad = (w_dim_m == 3'd0) || (w_dim_m > DIM_MAX) ||
                    (w_dim_n == 3'd0) || (w_dim_n > DIM_MAX);

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx      (uart_tx)
  );

  // NOTE: dbuf is a pure datapath buffer and is left out of reset; every
  // entry is written by the converter before SEND_DIGIT reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      w_rd_en      <= 1'b0;
      w_rd_addr    <= '0;
      w_busy       <= 1'b0;
      w_tx_done    <= 1'b0;
      w_error_flag <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      dim_m        <= '0;
      dim_n        <= '0;
      row          <= '0;
      col          <= '0;
      conv_val     <= '0;
      pow_idx      <= '0;
      digit        <= '0;
      started      <= 1'b0;
      dlen         <= '0;
      didx         <= '0;
      crlf_phase   <= '0;
    end else if (!w_en_output) begin
      // Abort: the transmitter keeps shifting any byte already started.
      state        <= IDLE;
      w_rd_en      <= 1'b0;
      w_busy       <= 1'b0;
      w_tx_done    <= 1'b0;
      w_error_flag <= 1'b0;
      tx_start     <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      w_tx_done <= 1'b0;
      w_rd_en   <= 1'b0;

      case (state)
        IDLE: begin
          if (w_start) begin
            if (dims_bad) begin
              w_error_flag <= 1'b1;
            end else begin
              w_error_flag <= 1'b0;
              w_busy       <= 1'b1;
              dim_m        <= w_dim_m;
              dim_n        <= w_dim_n;
              row          <= '0;
              col          <= '0;
              w_rd_en      <= 1'b1;
              w_rd_addr    <= w_base_addr;
              state        <= READ;
            end
          end
        end

        READ: state <= WAIT_RD;

        WAIT_RD: begin
          pow_idx <= 4'd9;
          digit   <= '0;
          started <= 1'b0;
`ifdef OUTPUT_SIGNED_EN
          if (w_rd_data[31]) begin
            conv_val <= -w_rd_data;
            dbuf[0]  <= ASC_MINUS;
            dlen     <= 4'd1;
          end else begin
            conv_val <= w_rd_data;
            dlen     <= '0;
          end
`else
          conv_val <= w_rd_data;
          dlen     <= '0;
`endif
          state <= CONV;
        end

        CONV: begin
          if (conv_val >= pow10(pow_idx)) begin
            conv_val <= conv_val - pow10(pow_idx);
            digit    <= digit + 4'd1;
          end else begin
            // Leading zeros are dropped, but the units digit always prints.
            if (started || digit != 4'd0 || pow_idx == 4'd0) begin
              dbuf[dlen] <= ASC_0 + {4'd0, digit};
              dlen       <= dlen + 4'd1;
              started    <= 1'b1;
            end
            digit <= '0;
            if (pow_idx == 4'd0) begin
              didx  <= '0;
              state <= SEND_DIGIT;
            end else begin
              pow_idx <= pow_idx - 4'd1;
            end
          end
        end

        SEND_DIGIT: begin
          if (can_send) begin
            tx_data  <= dbuf[didx];
            tx_start <= 1'b1;
            didx     <= didx + 4'd1;
            if (didx == dlen - 4'd1) begin
              crlf_phase <= '0;
              state      <= (col == dim_n - 3'd1) ? SEND_CRLF : SEND_SEP;
            end
          end
        end

        SEND_SEP: begin
          if (can_send) begin
            tx_data   <= ASC_SPACE;
            tx_start  <= 1'b1;
            col       <= col + 3'd1;
            w_rd_en   <= 1'b1;
            w_rd_addr <= w_rd_addr + 8'd1;
            state     <= READ;
          end
        end

        SEND_CRLF: begin
          if (can_send) begin
            case (crlf_phase)
              2'd0: begin
                tx_data    <= ASC_CR;
                tx_start   <= 1'b1;
                crlf_phase <= 2'd1;
              end
              2'd1: begin
                tx_data  <= ASC_LF;
                tx_start <= 1'b1;
                if (row == dim_m - 3'd1) begin
                  crlf_phase <= 2'd2;
                end else begin
                  row       <= row + 3'd1;
                  col       <= '0;
                  w_rd_en   <= 1'b1;
                  w_rd_addr <= w_rd_addr + 8'd1;
                  state     <= READ;
                end
              end
              default: begin
                // Reached only once the final LF stop bit has left the line.
                w_tx_done <= 1'b1;
                w_busy    <= 1'b0;
                state     <= DONE;
              end
            endcase
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_subsystem.sv
// Directed bench for output_subsystem: decodes the UART line into bytes and
// compares them, plus read addresses and status flags, against hand values.
module tb_output_subsystem;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 250_000;   // 4 clocks per bit, 40 per byte
  localparam int BUDGET    = 20_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en_output = 1'b1;
  logic        w_start = 1'b0;
  logic [7:0]  w_base_addr = '0;
  logic [2:0]  w_dim_m = 3'd1;
  logic [2:0]  w_dim_n = 3'd1;
  logic        w_rd_en;
  logic [7:0]  w_rd_addr;
  logic [31:0] w_rd_data = '0;
  logic        uart_tx;
  logic        w_busy;
  logic        w_tx_done;
  logic        w_error_flag;

  int compared = 0;
  int mismatched = 0;

  logic [31:0]   mem [256];
  byte unsigned  rx_q [$];
  logic [7:0]    rd_log [$];
  int            done_cnt = 0;

  output_subsystem #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_en_output (w_en_output),
    .w_start     (w_start),
    .w_base_addr (w_base_addr),
    .w_dim_m     (w_dim_m),
    .w_dim_n     (w_dim_n),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .uart_tx     (uart_tx),
    .w_busy      (w_busy),
    .w_tx_done   (w_tx_done),
    .w_error_flag(w_error_flag)
  );

  always #5 clk = ~clk;

  // Storage returns data the cycle after the read strobe.
  always @(posedge clk) if (w_rd_en === 1'b1) w_rd_data <= mem[w_rd_addr];

  always @(negedge clk) begin
    if (w_rd_en === 1'b1) rd_log.push_back(w_rd_addr);
    if (w_tx_done === 1'b1) done_cnt++;
  end

  // Line receiver: detect start, then sample mid-bit every 4 clocks.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic string rx_string(input int mark);
    string s = "";
    for (int i = mark; i < rx_q.size(); i++) s = {s, $sformatf("%c", rx_q[i])};
    return s;
  endfunction

  function automatic string hexify(input string s);
    string r = "";
    for (int i = 0; i < s.len() && i < 48; i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  task automatic pulse_start(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n);
    @(negedge clk);
    w_base_addr = base;
    w_dim_m     = m;
    w_dim_n     = n;
    w_start     = 1'b1;
    @(negedge clk);
    w_start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit hit);
    int mark = done_cnt;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != mark) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  // Runs one matrix to completion; settles afterwards so stray pulses show.
  task automatic run_matrix(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n,
                            output string got, output int dones, output bit hit);
    int rmark = rx_q.size();
    int dmark = done_cnt;
    pulse_start(base, m, n);
    wait_done(BUDGET, hit);
    repeat (60) @(negedge clk);
    got   = rx_string(rmark);
    dones = done_cnt - dmark;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared += 6;
    if (uart_tx !== 1'b1) begin mismatched++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    if (w_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en: got %b want 0", w_rd_en); end
    if (w_rd_addr !== 8'd0) begin mismatched++; $display("FAIL reset_rd_addr: got %0d want 0", w_rd_addr); end
    if (w_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", w_busy); end
    if (w_tx_done !== 1'b0) begin mismatched++; $display("FAIL reset_tx_done: got %b want 0", w_tx_done); end
    if (w_error_flag !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b want 0", w_error_flag); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_matrix_2x3();
    string exp = "1 2 3\r\n4 5 6\r\n";
    int rmark = rx_q.size();
    int dmark = done_cnt;
    bit hit;
    string got;
    for (int i = 0; i < 6; i++) mem[8'd10 + i[7:0]] = 32'(i + 1);
    mem[100] = 32'd9;
    pulse_start(8'd10, 3'd2, 3'd3);
    compared++;
    if (w_busy !== 1'b1) begin mismatched++; $display("FAIL busy_after_start: got %b want 1", w_busy); end
    // A second start while busy must have no effect.
    repeat (100) @(negedge clk);
    pulse_start(8'd100, 3'd1, 3'd1);
    wait_done(BUDGET, hit);
    compared++;
    if (!hit) begin mismatched++; $display("FAIL m2x3_done_timeout: got no w_tx_done want pulse"); end
    repeat (60) @(negedge clk);
    got = rx_string(rmark);
    compared += 4;
    if (got != exp) begin mismatched++; $display("FAIL m2x3_bytes: got [%s] want [%s]", hexify(got), hexify(exp)); end
    if (done_cnt - dmark != 1) begin mismatched++; $display("FAIL m2x3_done_count: got %0d want 1", done_cnt - dmark); end
    if (w_busy !== 1'b0) begin mismatched++; $display("FAIL m2x3_busy_end: got %b want 0", w_busy); end
    if (w_error_flag !== 1'b0) begin mismatched++; $display("FAIL m2x3_error: got %b want 0", w_error_flag); end
  endtask

  task automatic test_single_values();
    string got;
    int dones;
    bit hit;
    mem[40] = 32'd0;
    run_matrix(8'd40, 3'd1, 3'd1, got, dones, hit);
    compared += 2;
    if (!hit || dones != 1) begin mismatched++; $display("FAIL zero_done: got hit=%0d count=%0d want 1", hit, dones); end
    if (got != "0\r\n") begin mismatched++; $display("FAIL zero_bytes: got [%s] want [30 0d 0a]", hexify(got)); end
    mem[41] = 32'hFFFF_FFFF;
    run_matrix(8'd41, 3'd1, 3'd1, got, dones, hit);
    compared += 2;
    if (!hit || dones != 1) begin mismatched++; $display("FAIL max_done: got hit=%0d count=%0d want 1", hit, dones); end
    if (got != "4294967295\r\n") begin mismatched++; $display("FAIL max_bytes: got [%s] want [%s]", hexify(got), hexify("4294967295\r\n")); end
  endtask

  task automatic test_dim_error();
    logic [2:0] ms [2] = '{3'd0, 3'd2};
    logic [2:0] ns [2] = '{3'd3, 3'd6};
    string got;
    int dones;
    bit hit;
    for (int k = 0; k < 2; k++) begin
      bit line_low = 1'b0;
      bit busy_seen = 1'b0;
      pulse_start(8'd0, ms[k], ns[k]);
      compared++;
      if (w_error_flag !== 1'b1) begin mismatched++; $display("FAIL dim_error_flag_%0d: got %b want 1", k, w_error_flag); end
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (uart_tx !== 1'b1) line_low = 1'b1;
        if (w_busy !== 1'b0) busy_seen = 1'b1;
      end
      compared += 3;
      if (line_low) begin mismatched++; $display("FAIL dim_error_line_%0d: got low want idle high", k); end
      if (busy_seen) begin mismatched++; $display("FAIL dim_error_busy_%0d: got 1 want 0", k); end
      if (w_error_flag !== 1'b1) begin mismatched++; $display("FAIL dim_error_sticky_%0d: got %b want 1", k, w_error_flag); end
    end
    // Enable low clears the flag; a start while disabled is ignored.
    @(negedge clk);
    w_en_output = 1'b0;
    pulse_start(8'd0, 3'd1, 3'd1);
    compared += 2;
    if (w_error_flag !== 1'b0) begin mismatched++; $display("FAIL error_clear_en: got %b want 0", w_error_flag); end
    if (w_busy !== 1'b0) begin mismatched++; $display("FAIL start_while_disabled: got busy %b want 0", w_busy); end
    w_en_output = 1'b1;
    pulse_start(8'd0, 3'd0, 3'd1);
    mem[0] = 32'd7;
    pulse_start(8'd0, 3'd1, 3'd1);
    compared++;
    if (w_error_flag !== 1'b0) begin mismatched++; $display("FAIL error_clear_start: got %b want 0", w_error_flag); end
    wait_done(BUDGET, hit);
    repeat (60) @(negedge clk);
    compared++;
    if (!hit) begin mismatched++; $display("FAIL error_recover_done: got no w_tx_done want pulse"); end
    got = "";
    dones = 0;
  endtask

  task automatic test_signed();
    string got;
    string exp;
    int dones;
    bit hit;
`ifdef OUTPUT_SIGNED_EN
    exp = "-10\r\n";
`else
    exp = "4294967286\r\n";
`endif
    mem[60] = 32'hFFFF_FFF6;
    run_matrix(8'd60, 3'd1, 3'd1, got, dones, hit);
    compared += 2;
    if (!hit || dones != 1) begin mismatched++; $display("FAIL neg_done: got hit=%0d count=%0d want 1", hit, dones); end
    if (got != exp) begin mismatched++; $display("FAIL neg_bytes: got [%s] want [%s]", hexify(got), hexify(exp)); end
  endtask

  task automatic test_abort_restart();
    string exp = "";
    string got;
    int rmark;
    int dmark;
    int dones;
    bit hit = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        mem[8'd20 + 8'(r * 5 + c)] = 32'(10 * (r + 1) + c + 1);
        exp = {exp, $sformatf("%0d", 10 * (r + 1) + c + 1), (c == 4) ? "\r\n" : " "};
      end
    rmark = rd_log.size();
    dmark = done_cnt;
    pulse_start(8'd20, 3'd5, 3'd5);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (rd_log.size() - rmark >= 7) begin hit = 1'b1; break; end
    end
    compared++;
    if (!hit) begin mismatched++; $display("FAIL abort_reach_row2: got %0d reads want 7", rd_log.size() - rmark); end
    w_en_output = 1'b0;
    @(negedge clk);
    compared += 2;
    if (w_busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy_next_cycle: got %b want 0", w_busy); end
    if (w_rd_en !== 1'b0) begin mismatched++; $display("FAIL abort_rd_en: got %b want 0", w_rd_en); end
    repeat (100) @(negedge clk);
    compared += 2;
    if (done_cnt != dmark) begin mismatched++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - dmark); end
    if (uart_tx !== 1'b1) begin mismatched++; $display("FAIL abort_line_idle: got %b want 1", uart_tx); end
    w_en_output = 1'b1;
    repeat (10) @(negedge clk);
    run_matrix(8'd20, 3'd5, 3'd5, got, dones, hit);
    compared += 2;
    if (!hit || dones != 1) begin mismatched++; $display("FAIL restart_done: got hit=%0d count=%0d want 1", hit, dones); end
    if (got != exp) begin mismatched++; $display("FAIL restart_bytes: got [%s] want [%s]", hexify(got), hexify(exp)); end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] exp_addr [9] = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2};
    string got;
    int dones;
    bit hit;
    bit addr_ok = 1'b1;
    int rmark = rd_log.size();
    for (int i = 0; i < 9; i++) mem[exp_addr[i]] = 32'(i + 1);
    run_matrix(8'd250, 3'd3, 3'd3, got, dones, hit);
    compared += 4;
    if (!hit || dones != 1) begin mismatched++; $display("FAIL wrap_done: got hit=%0d count=%0d want 1", hit, dones); end
    if (rd_log.size() - rmark != 9) begin mismatched++; $display("FAIL wrap_read_count: got %0d want 9", rd_log.size() - rmark); end
    else begin
      for (int i = 0; i < 9; i++) if (rd_log[rmark + i] !== exp_addr[i]) addr_ok = 1'b0;
      if (!addr_ok) begin
        mismatched++;
        $display("FAIL wrap_addresses: got %0d %0d %0d %0d %0d %0d %0d %0d %0d want 250..255 0 1 2",
                 rd_log[rmark], rd_log[rmark+1], rd_log[rmark+2], rd_log[rmark+3], rd_log[rmark+4],
                 rd_log[rmark+5], rd_log[rmark+6], rd_log[rmark+7], rd_log[rmark+8]);
      end
    end
    if (got != "1 2 3\r\n4 5 6\r\n7 8 9\r\n") begin mismatched++; $display("FAIL wrap_bytes: got [%s]", hexify(got)); end
  endtask

  initial begin
    test_reset();
    test_matrix_2x3();
    test_single_values();
    test_dim_error();
    test_signed();
    test_abort_restart();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
